// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/stall controller: forwarding selects and FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_EXE     = 2'b01,
    FWD_MEM_ALU = 2'b10,
    FWD_MEM_LD  = 2'b11
  } fwd_e;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  // EXE outranks MEM; register 0 is hard-wired and never forwards.
  function automatic fwd_e fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ex_rn,
    input logic       ex_wreg,
    input logic       ex_m2reg,
    input logic [4:0] mem_rn,
    input logic       mem_wreg,
    input logic       mem_m2reg
  );
    if (ex_wreg && !ex_m2reg && ex_rn != 5'd0 && ex_rn == src)
      return FWD_EXE;
    else if (mem_wreg && !mem_m2reg && mem_rn != 5'd0 && mem_rn == src)
      return FWD_MEM_ALU;
    else if (mem_wreg && mem_m2reg && mem_rn != 5'd0 && mem_rn == src)
      return FWD_MEM_LD;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the EXE/MEM destination and control bits, tracking the real
// pipeline registers including bubble insertion at ID/EXE.
module hazard_shadow_pipe (
  input  logic       clk,
  input  logic       clrn,
  input  logic       bubble,
  input  logic [4:0] id_rn,
  input  logic       id_wreg,
  input  logic       id_m2reg,
  input  logic       id_wz,
  output logic [4:0] ex_rn,
  output logic       ex_wreg,
  output logic       ex_m2reg,
  output logic       ex_wz,
  output logic [4:0] mem_rn,
  output logic       mem_wreg,
  output logic       mem_m2reg
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ex_rn     <= '0;
      ex_wreg   <= 1'b0;
      ex_m2reg  <= 1'b0;
      ex_wz     <= 1'b0;
      mem_rn    <= '0;
      mem_wreg  <= 1'b0;
      mem_m2reg <= 1'b0;
    end else begin
      mem_rn    <= ex_rn;
      mem_wreg  <= ex_wreg;
      mem_m2reg <= ex_m2reg;
      // A bubble only kills the control bits; the destination field is left as-is.
      if (bubble) begin
        ex_wreg  <= 1'b0;
        ex_m2reg <= 1'b0;
        ex_wz    <= 1'b0;
      end else begin
        ex_rn    <= id_rn;
        ex_wreg  <= id_wreg;
        ex_m2reg <= id_m2reg;
        ex_wz    <= id_wz;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / Z-flag hazard detection, multi-cycle bubble FSM, operand forwarding
// selects and a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_use_z,
  input  logic [4:0]       id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_wz,
  output logic             lock_write,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [4:0] ex_rn, mem_rn;
  logic       ex_wreg, ex_m2reg, ex_wz;
  logic       mem_wreg, mem_m2reg;

  state_e     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic       load_use, z_haz;

  hazard_shadow_pipe u_shadow (
    .clk       (clk),
    .clrn      (clrn),
    .bubble    (lock_write),
    .id_rn     (id_rn),
    .id_wreg   (id_wreg),
    .id_m2reg  (id_m2reg),
    .id_wz     (id_wz),
    .ex_rn     (ex_rn),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_wz     (ex_wz),
    .mem_rn    (mem_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg)
  );

  always_comb begin
    load_use = ex_wreg && ex_m2reg && (ex_rn != 5'd0) &&
               ((id_use_rs && id_rs == ex_rn) || (id_use_rt && id_rt == ex_rn));
    z_haz    = id_use_z && ex_wz;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    lock_write = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_use) begin
          lock_write = 1'b1;
          if (LOAD_LAT > 1) begin
            state_n = STALL;
            cnt_n   = 3'(LOAD_LAT - 1);
          end
        end else if (z_haz) begin
          lock_write = 1'b1;
        end
      end
      STALL: begin
        lock_write = 1'b1;
        cnt_n      = cnt - 3'd1;
        if (cnt == 3'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pc_hold   = lock_write;
  assign ifid_hold = lock_write;

  assign fwd_a = fwd_sel(id_rs, ex_rn, ex_wreg, ex_m2reg, mem_rn, mem_wreg, mem_m2reg);
  assign fwd_b = fwd_sel(id_rt, ex_rn, ex_wreg, ex_m2reg, mem_rn, mem_wreg, mem_m2reg);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      stall_cycles <= '0;
    else if (lock_write && stall_cycles != '1)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: three controller instances (LOAD_LAT 1/3/4) share one stimulus stream.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] id_rs, id_rt, id_rn;
  logic       id_use_rs, id_use_rt, id_use_z, id_wreg, id_m2reg, id_wz;

  logic        l1, ph1, ih1;  logic [1:0] fa1, fb1;  logic [15:0] sc1;
  logic        l3, ph3, ih3;  logic [1:0] fa3, fb3;  logic [15:0] sc3;
  logic        l4, ph4, ih4;  logic [1:0] fa4, fb4;  logic [3:0]  sc4;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_use_z(id_use_z), .id_rn(id_rn), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wz(id_wz), .lock_write(l1), .pc_hold(ph1),
    .ifid_hold(ih1), .fwd_a(fa1), .fwd_b(fb1), .stall_cycles(sc1));

  hazard_stall_ctrl #(.LOAD_LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_use_z(id_use_z), .id_rn(id_rn), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wz(id_wz), .lock_write(l3), .pc_hold(ph3),
    .ifid_hold(ih3), .fwd_a(fa3), .fwd_b(fb3), .stall_cycles(sc3));

  hazard_stall_ctrl #(.LOAD_LAT(4), .CNT_W(4)) u4 (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_use_z(id_use_z), .id_rn(id_rn), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wz(id_wz), .lock_write(l4), .pc_hold(ph4),
    .ifid_hold(ih4), .fwd_a(fa4), .fwd_b(fb4), .stall_cycles(sc4));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic uz, input logic [4:0] rn,
                        input logic wreg, input logic m2reg, input logic wz);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_use_z = uz;
    id_rn = rn; id_wreg = wreg; id_m2reg = m2reg; id_wz = wz;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    clrn = 1'b0;
    #1;
    clrn = 1'b1;
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_lock", {15'd0, l1}, 16'd0);
    chk("rst_hold", {14'd0, ph1, ih1}, 16'd0);
    chk("rst_fwd",  {12'd0, fa1, fb1}, 16'd0);
    chk("rst_cnt",  sc1, 16'd0);
    #10 clrn = 1'b1;
    tick;

    // LOAD_LAT=1 load-use: load r5 then add reading r5
    set_id(0, 0, 0, 0, 0, 5, 1, 1, 0); #1;
    chk("lu1_n_lock", {15'd0, l1}, 16'd0);
    tick;
    set_id(5, 0, 1, 0, 0, 6, 1, 0, 0); #1;
    chk("lu1_n1_lock", {15'd0, l1}, 16'd1);
    chk("lu1_n1_hold", {14'd0, ph1, ih1}, 16'd3);
    chk("lu1_n1_fwd", {14'd0, fa1}, 16'd0);
    tick;
    chk("lu1_n2_lock", {15'd0, l1}, 16'd0);
    chk("lu1_n2_fwda", {14'd0, fa1}, 16'd3);
    chk("lu1_n2_cnt", sc1, 16'd1);
    tick;
    do_reset;

    // LOAD_LAT=3 same stimulus on u3
    set_id(0, 0, 0, 0, 0, 5, 1, 1, 0); #1;
    tick;
    set_id(5, 0, 1, 0, 0, 6, 1, 0, 0); #1;
    chk("lu3_c1_lock", {15'd0, l3}, 16'd1);
    tick;
    chk("lu3_c2_lock", {15'd0, l3}, 16'd1);
    chk("lu3_c2_fwda", {14'd0, fa3}, 16'd3);
    tick;
    chk("lu3_c3_lock", {15'd0, l3}, 16'd1);
    chk("lu3_c3_fwda", {14'd0, fa3}, 16'd0);
    tick;
    chk("lu3_c4_lock", {15'd0, l3}, 16'd0);
    chk("lu3_c4_cnt", sc3, 16'd3);
    chk("lu3_c4_fwda", {14'd0, fa3}, 16'd0);
    tick;
    do_reset;

    // forwarding priority: r7 in EXE and MEM
    set_id(0, 0, 0, 0, 0, 7, 1, 0, 0); #1; tick;
    set_id(0, 0, 0, 0, 0, 7, 1, 0, 0); #1; tick;
    set_id(7, 7, 1, 1, 0, 8, 1, 0, 0); #1;
    chk("fwd_exe_a", {14'd0, fa1}, 16'd1);
    chk("fwd_exe_b", {14'd0, fb1}, 16'd1);
    chk("fwd_exe_lock", {15'd0, l1}, 16'd0);
    tick;
    do_reset;
    set_id(0, 0, 0, 0, 0, 7, 1, 0, 0); #1; tick;
    set_id(0, 0, 0, 0, 0, 0, 1, 0, 0); #1; tick;
    set_id(7, 7, 1, 1, 0, 8, 1, 0, 0); #1;
    chk("fwd_mem_a", {14'd0, fa1}, 16'd2);
    chk("fwd_mem_b", {14'd0, fb1}, 16'd2);
    set_id(0, 7, 0, 0, 0, 8, 1, 0, 0); #1;
    chk("fwd_r0_a", {14'd0, fa1}, 16'd0);
    chk("fwd_nouse_b", {14'd0, fb1}, 16'd2);
    tick;
    do_reset;

    // Z hazard on u3: single bubble
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1); #1; tick;
    set_id(0, 0, 0, 0, 1, 0, 0, 0, 0); #1;
    chk("z_c1_lock", {15'd0, l3}, 16'd1);
    tick;
    chk("z_c2_lock", {15'd0, l3}, 16'd0);
    chk("z_c2_cnt", sc3, 16'd1);
    tick;
    do_reset;

    // load-use and Z hazard together: full LOAD_LAT stall
    set_id(0, 0, 0, 0, 0, 5, 1, 1, 1); #1; tick;
    set_id(5, 0, 1, 0, 1, 6, 1, 0, 0); #1;
    chk("lz_c1_lock", {15'd0, l3}, 16'd1);
    tick;
    chk("lz_c2_lock", {15'd0, l3}, 16'd1);
    tick;
    chk("lz_c3_lock", {15'd0, l3}, 16'd1);
    tick;
    chk("lz_c4_lock", {15'd0, l3}, 16'd0);
    chk("lz_c4_cnt", sc3, 16'd3);
    tick;
    do_reset;

    // LOAD_LAT=4: reset asserted after two stall cycles
    set_id(0, 0, 0, 0, 0, 5, 1, 1, 0); #1; tick;
    set_id(5, 0, 1, 0, 0, 6, 1, 0, 0); #1;
    chk("rs_c1_lock", {15'd0, l4}, 16'd1);
    tick;
    chk("rs_c2_lock", {15'd0, l4}, 16'd1);
    tick;
    chk("rs_c3_cnt", {12'd0, sc4}, 16'd2);
    chk("rs_c3_lock", {15'd0, l4}, 16'd1);
    clrn = 1'b0;
    #1;
    chk("rs_async_lock", {15'd0, l4}, 16'd0);
    chk("rs_async_hold", {14'd0, ph4, ih4}, 16'd0);
    chk("rs_async_cnt", {12'd0, sc4}, 16'd0);
    chk("rs_async_fwd", {12'd0, fa4, fb4}, 16'd0);
    clrn = 1'b1;
    tick;
    do_reset;

    // saturation with CNT_W=4: repeated load-use stalls (4 on, 1 off)
    set_id(5, 0, 1, 0, 0, 5, 1, 1, 0);
    repeat (6) tick;
    chk("sat_partial", {12'd0, sc4}, 16'd4);
    repeat (24) tick;
    chk("sat_15", {12'd0, sc4}, 16'd15);
    repeat (3) tick;
    chk("sat_hold", {12'd0, sc4}, 16'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
